// File: rtl/majority_pkg.sv
// majority_pkg -- shared constants for the majority voter slice.
//   MODE_BITWISE / MODE_WORD : voting mode selectors
//   *_MIN / *_MAX            : legal parameter ranges
//   CNT_W                    : width of the per-channel mismatch counters
//   n_ch_ok()                : legality test for the channel count
package majority_pkg;

    localparam int MODE_BITWISE    = 32'sd0;
    localparam int MODE_WORD       = 32'sd1;

    localparam int N_CH_MIN        = 32'sd3;
    localparam int N_CH_MAX        = 32'sd7;
    localparam int WIDTH_MIN       = 32'sd1;
    localparam int WIDTH_MAX       = 32'sd32;
    localparam int FAULT_LIMIT_MIN = 32'sd1;
    localparam int FAULT_LIMIT_MAX = 32'sd15;

    localparam int CNT_W           = 32'sd4;

    // A channel count is legal when it is odd and inside the supported range.
    function automatic bit n_ch_ok(input int n);
        return (n >= N_CH_MIN) && (n <= N_CH_MAX) && (n[0] == 1'b1);
    endfunction

endpackage

// File: rtl/majority_bit.sv
// majority_bit -- combinational popcount majority of one bit column.
//   bits : one bit from each of the N_CH channels
//   maj  : 1 when more than N_CH/2 of the bits are 1
module majority_bit
    import majority_pkg::*;
#(
    parameter int N_CH = 3
) (
    input  logic [N_CH-1:0] bits,
    output logic            maj
);

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'((N_CH - 32'sd1) >>> 32'sd1);

    logic [CNT_W-1:0] ones_s;

    // Count the ones in the column.
    always_comb begin
        ones_s = {CNT_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            ones_s = ones_s + {{(CNT_W-1){1'b0}}, bits[i]};
        end
    end

    assign maj = (ones_s > HALF_C);

endmodule

// File: rtl/majority_voter.sv
// majority_voter -- N-channel redundant voter with per-channel fault tracking.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : sample handshake; data_in packs channel i at [i*WIDTH +: WIDTH]
//   clear_fail            : pulse that clears all mismatch counters and ch_fail
//   out_valid / out_ready : result handshake for data_out, vote_ok, disagree
//   ch_fail               : sticky per-channel failure flags
// MODE 0 votes each bit column independently; MODE 1 votes whole words and
// reports vote_ok=0 (holding the previous word) when no word has a majority.
module majority_voter
    import majority_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int WIDTH       = 8,
    parameter int MODE        = 0,
    parameter int FAULT_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CH*WIDTH-1:0] data_in,
    input  logic                 clear_fail,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     data_out,
    output logic                 vote_ok,
    output logic [N_CH-1:0]      disagree,
    output logic [N_CH-1:0]      ch_fail
);

    // Illegal parameterisations stop elaboration.
    if (!n_ch_ok(N_CH)) begin : g_bad_n_ch
        $fatal(1, "majority_voter: N_CH must be odd and within 3..7");
    end
    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $fatal(1, "majority_voter: WIDTH must be within 1..32");
    end
    if ((MODE != MODE_BITWISE) && (MODE != MODE_WORD)) begin : g_bad_mode
        $fatal(1, "majority_voter: MODE must be 0 or 1");
    end
    if ((FAULT_LIMIT < FAULT_LIMIT_MIN) || (FAULT_LIMIT > FAULT_LIMIT_MAX)) begin : g_bad_limit
        $fatal(1, "majority_voter: FAULT_LIMIT must be within 1..15");
    end

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(FAULT_LIMIT);
    localparam logic [CNT_W-1:0] HALF_C  = CNT_W'((N_CH - 32'sd1) >>> 32'sd1);

    logic [WIDTH-1:0] ch_s [N_CH];
    logic [WIDTH-1:0] vote_word_s;
    logic             vote_ok_s;
    logic [N_CH-1:0]  disagree_s;
    logic             accept_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] data_out_r;
    logic             vote_ok_r;
    logic [N_CH-1:0]  disagree_r;
    logic [N_CH-1:0]  fail_r;
    logic [CNT_W-1:0] cnt_r     [N_CH];
    logic [CNT_W-1:0] cnt_nxt_s [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_s[i] = data_in[i*WIDTH +: WIDTH];
    end

    if (MODE == MODE_BITWISE) begin : g_bitwise
        logic [WIDTH-1:0] bitwise_s;
        for (genvar b = 0; b < WIDTH; b++) begin : g_col
            logic [N_CH-1:0] col_s;
            for (genvar i = 0; i < N_CH; i++) begin : g_pick
                assign col_s[i] = ch_s[i][b];
            end
            majority_bit #(.N_CH(N_CH)) u_bit (
                .bits (col_s),
                .maj  (bitwise_s[b])
            );
        end
        assign vote_word_s = bitwise_s;
        assign vote_ok_s   = 1'b1;
    end else begin : g_word
        logic [WIDTH-1:0] word_s;
        logic             found_s;
        logic [CNT_W-1:0] agree_v;

        // Pick the first channel whose word is shared by a majority; without
        // one the previous output word is repeated.
        always_comb begin
            word_s  = data_out_r;
            found_s = 1'b0;
            agree_v = {CNT_W{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                agree_v = {CNT_W{1'b0}};
                for (int j = 0; j < N_CH; j++) begin
                    if (ch_s[j] == ch_s[i]) begin
                        agree_v = agree_v + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        agree_v = agree_v;
                    end
                end
                if (!found_s && (agree_v > HALF_C)) begin
                    word_s  = ch_s[i];
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end

        assign vote_word_s = word_s;
        assign vote_ok_s   = found_s;
    end

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Per-channel disagreement; a failed word vote flags every channel.
    always_comb begin
        disagree_s = {N_CH{1'b1}};
        if (vote_ok_s) begin
            for (int i = 0; i < N_CH; i++) begin
                disagree_s[i] = (ch_s[i] != vote_word_s);
            end
        end else begin
            disagree_s = {N_CH{1'b1}};
        end
    end

    // Next mismatch count: saturating increment on mismatch, zero on match.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (disagree_s[i]) begin
                if (cnt_r[i] >= LIMIT_C) begin
                    cnt_nxt_s[i] = LIMIT_C;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end
        end
    end

    // Result register: load on accept, drop valid after a bare handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            data_out_r  <= {WIDTH{1'b0}};
            vote_ok_r   <= 1'b0;
            disagree_r  <= {N_CH{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            data_out_r  <= vote_word_s;
            vote_ok_r   <= vote_ok_s;
            disagree_r  <= disagree_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Fault tracking; clear_fail takes priority over a coincident sample and
    // samples without a valid vote leave the state untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            fail_r <= {N_CH{1'b0}};
        end else if (clear_fail) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            fail_r <= {N_CH{1'b0}};
        end else if (accept_s && vote_ok_s) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
                if (cnt_nxt_s[i] == LIMIT_C) begin
                    fail_r[i] <= 1'b1;
                end else begin
                    fail_r[i] <= fail_r[i];
                end
            end
        end else begin
            fail_r <= fail_r;
        end
    end

    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
    assign vote_ok   = vote_ok_r;
    assign disagree  = disagree_r;
    assign ch_fail   = fail_r;

endmodule

// File: tb/tb_majority_voter.sv
// tb_majority_voter -- directed bench driving a bitwise-mode and a word-mode
// voter (N_CH=3, WIDTH=8, FAULT_LIMIT=3) from the same input stimulus.
module tb_majority_voter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] data_in;
    logic        clear_fail;
    logic        out_ready;

    logic        ir0, ov0, ok0;
    logic [7:0]  do0;
    logic [2:0]  dis0, cf0;
    logic        ir1, ov1, ok1;
    logic [7:0]  do1;
    logic [2:0]  dis1, cf1;

    int n_cmp = 0;
    int n_err = 0;

    majority_voter #(.N_CH(3), .WIDTH(8), .MODE(0), .FAULT_LIMIT(3)) u_dut_bit (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .data_in(data_in), .clear_fail(clear_fail), .out_valid(ov0),
        .out_ready(out_ready), .data_out(do0), .vote_ok(ok0),
        .disagree(dis0), .ch_fail(cf0)
    );

    majority_voter #(.N_CH(3), .WIDTH(8), .MODE(1), .FAULT_LIMIT(3)) u_dut_word (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .data_in(data_in), .clear_fail(clear_fail), .out_valid(ov1),
        .out_ready(out_ready), .data_out(do1), .vote_ok(ok1),
        .disagree(dis1), .ch_fail(cf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic res(input int d, input string tag, input logic ov,
                       input logic [7:0] dout, input logic ok, input logic [2:0] dis);
        if (d == 0) begin
            chk({tag, ".bit.ov"},  {31'd0, ov0}, {31'd0, ov});
            chk({tag, ".bit.do"},  {24'd0, do0}, {24'd0, dout});
            chk({tag, ".bit.ok"},  {31'd0, ok0}, {31'd0, ok});
            chk({tag, ".bit.dis"}, {29'd0, dis0}, {29'd0, dis});
        end else begin
            chk({tag, ".word.ov"},  {31'd0, ov1}, {31'd0, ov});
            chk({tag, ".word.do"},  {24'd0, do1}, {24'd0, dout});
            chk({tag, ".word.ok"},  {31'd0, ok1}, {31'd0, ok});
            chk({tag, ".word.dis"}, {29'd0, dis1}, {29'd0, dis});
        end
    endtask

    task automatic fails(input string tag, input logic [2:0] e0, input logic [2:0] e1);
        chk({tag, ".bit.fail"},  {29'd0, cf0}, {29'd0, e0});
        chk({tag, ".word.fail"}, {29'd0, cf1}, {29'd0, e1});
    endtask

    task automatic ready(input string tag, input logic e);
        chk({tag, ".bit.ir"},  {31'd0, ir0}, {31'd0, e});
        chk({tag, ".word.ir"}, {31'd0, ir1}, {31'd0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse(input string tag);
        in_valid   = 1'b0;
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        chk({tag, ".bit.ov"},  {31'd0, ov0}, 32'd0);
        chk({tag, ".word.ov"}, {31'd0, ov1}, 32'd0);
        fails(tag, 3'b000, 3'b000);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        data_in    = 24'h000000;
        clear_fail = 1'b0;
        out_ready  = 1'b1;
        #1;
        res(0, "reset", 1'b0, 8'h00, 1'b0, 3'b000);
        res(1, "reset", 1'b0, 8'h00, 1'b0, 3'b000);
        fails("reset", 3'b000, 3'b000);
        ready("reset", 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Three distinct words: bitwise gives E8, word vote has no majority.
        data_in  = {8'hAA, 8'hCC, 8'hF0};
        in_valid = 1'b1;
        tick();
        res(0, "vote_e8", 1'b1, 8'hE8, 1'b1, 3'b111);
        res(1, "vote_e8", 1'b1, 8'h00, 1'b0, 3'b111);

        // Unanimous 77 establishes the previous word.
        data_in = {8'h77, 8'h77, 8'h77};
        tick();
        res(0, "all77", 1'b1, 8'h77, 1'b1, 3'b000);
        res(1, "all77", 1'b1, 8'h77, 1'b1, 3'b000);

        // No word majority, three times: word mode holds 77 and never counts,
        // bitwise mode (0x16) mismatches every channel and fails all three.
        data_in = {8'h56, 8'h34, 8'h12};
        tick();
        res(0, "nomaj1", 1'b1, 8'h16, 1'b1, 3'b111);
        res(1, "nomaj1", 1'b1, 8'h77, 1'b0, 3'b111);
        fails("nomaj1", 3'b000, 3'b000);
        tick();
        fails("nomaj2", 3'b000, 3'b000);
        tick();
        res(1, "nomaj3", 1'b1, 8'h77, 1'b0, 3'b111);
        fails("nomaj3", 3'b111, 3'b000);
        clear_pulse("clr1");

        // Channel 2 off on three consecutive samples.
        data_in  = {8'hA5, 8'h5A, 8'h5A};
        in_valid = 1'b1;
        tick();
        res(0, "ch2_1", 1'b1, 8'h5A, 1'b1, 3'b100);
        res(1, "ch2_1", 1'b1, 8'h5A, 1'b1, 3'b100);
        fails("ch2_1", 3'b000, 3'b000);
        tick();
        fails("ch2_2", 3'b000, 3'b000);
        tick();
        fails("ch2_3", 3'b100, 3'b100);
        data_in = {8'h5A, 8'h5A, 8'h5A};
        tick();
        res(0, "ch2_match", 1'b1, 8'h5A, 1'b1, 3'b000);
        fails("ch2_match", 3'b100, 3'b100);
        clear_pulse("clr2");

        // Channel 0 off; clear coincides with the third mismatch.
        data_in  = {8'h3C, 8'h3C, 8'h0F};
        in_valid = 1'b1;
        tick();
        tick();
        fails("ch0_2", 3'b000, 3'b000);
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        res(0, "ch0_clr", 1'b1, 8'h3C, 1'b1, 3'b001);
        res(1, "ch0_clr", 1'b1, 8'h3C, 1'b1, 3'b001);
        fails("ch0_clr", 3'b000, 3'b000);
        tick();
        tick();
        fails("ch0_after2", 3'b000, 3'b000);
        tick();
        fails("ch0_after3", 3'b001, 3'b001);
        in_valid = 1'b0;
        tick();
        res(0, "drain", 1'b0, 8'h3C, 1'b1, 3'b001);

        // Backpressure: one result held for four stalled cycles.
        data_in   = {8'h11, 8'h11, 8'h11};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        res(0, "bp_load", 1'b1, 8'h11, 1'b1, 3'b000);
        data_in = {8'h22, 8'h22, 8'h22};
        ready("bp_stall", 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            res(0, "bp_hold", 1'b1, 8'h11, 1'b1, 3'b000);
            res(1, "bp_hold", 1'b1, 8'h11, 1'b1, 3'b000);
            ready("bp_hold", 1'b0);
        end
        out_ready = 1'b1;
        #1;
        ready("bp_release", 1'b1);
        tick();
        res(0, "bp_next", 1'b1, 8'h22, 1'b1, 3'b000);
        res(1, "bp_next", 1'b1, 8'h22, 1'b1, 3'b000);
        in_valid = 1'b0;
        tick();
        res(0, "bp_done", 1'b0, 8'h22, 1'b1, 3'b000);
        res(1, "bp_done", 1'b0, 8'h22, 1'b1, 3'b000);
        fails("bp_done", 3'b001, 3'b001);

        // Asynchronous reset between edges while a result is pending.
        data_in   = {8'h33, 8'h33, 8'h33};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        res(0, "pre_rst", 1'b1, 8'h33, 1'b1, 3'b000);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        res(0, "async_rst", 1'b0, 8'h00, 1'b0, 3'b000);
        res(1, "async_rst", 1'b0, 8'h00, 1'b0, 3'b000);
        fails("async_rst", 3'b000, 3'b000);
        ready("async_rst", 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready("post_rst", 1'b1);

        // Word mode repeats the reset value, not the pre-reset 33.
        data_in   = {8'hAA, 8'hCC, 8'hF0};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        res(0, "post_rst_vote", 1'b1, 8'hE8, 1'b1, 3'b111);
        res(1, "post_rst_vote", 1'b1, 8'h00, 1'b0, 3'b111);
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/majority_voter.md
MAJORITY_VOTER -- requirements
Module: majority_voter

Interface
REQ-001 Parameter N_CH, default 3: number of redundant channels voted; SHALL be odd, range 3..7.
REQ-002 Parameter WIDTH, default 8: bits per channel word, range 1..32.
REQ-003 Parameter MODE, default 0: 0 = bitwise vote, 1 = whole-word vote.
REQ-004 Parameter FAULT_LIMIT, default 3: consecutive mismatching samples before a channel is declared failed, range 1..15.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  data_in holds a sample.
REQ-008 in_ready  out  1  block can accept a sample.
REQ-009 data_in  in  N_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-010 clear_fail  in  1  one-cycle pulse; clears all fault state.
REQ-011 out_valid  out  1  data_out/vote_ok/disagree hold a result.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 data_out  out  WIDTH  voted word.
REQ-014 vote_ok  out  1  a majority existed for this result.
REQ-015 disagree  out  N_CH  bit i set if channel i differed from data_out for this result.
REQ-016 ch_fail  out  N_CH  bit i set while channel i is declared failed.

Function
REQ-017 Sample accepted on a rising edge with in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no input-to-output combinational path other than this).
REQ-018 Latency one cycle: result of an accepted sample is registered and out_valid rises the next cycle; back-to-back throughput one sample/cycle while out_ready=1.
REQ-019 out_valid, data_out, vote_ok, disagree SHALL hold stable while out_valid && !out_ready; out_valid falls after handshake if no new sample is accepted the same edge.
REQ-020 MODE 0: data_out bit b = 1 iff more than N_CH/2 channels have bit b = 1; vote_ok always 1.
REQ-021 MODE 1: data_out = word equal in more than N_CH/2 channels, vote_ok = 1; if no such word, vote_ok = 0, data_out repeats the previous data_out value (0 after reset), disagree = all ones.
REQ-022 Per-channel mismatch counter, width 4, updates only on accepted samples with a valid vote: mismatch -> increment saturating at FAULT_LIMIT; match -> 0.
REQ-023 ch_fail[i] sets when counter i reaches FAULT_LIMIT, sticky; a later match zeroes the counter but does not clear ch_fail.
REQ-024 Accepted sample with vote_ok = 0 SHALL leave counters and ch_fail unchanged.
REQ-025 clear_fail zeroes all counters and ch_fail; if coincident with an accepted sample, clear wins and that sample's mismatches are not counted (its result is still output).
REQ-026 Voting uses all channels regardless of ch_fail.

Reset
REQ-027 rst_n low: out_valid=0, data_out=0, vote_ok=0, disagree=0, ch_fail=0, counters=0, immediately and independent of clk.
REQ-028 Reset mid-transfer discards the pending result; in_ready = 1 while rst_n is low and after release.

Structure
REQ-029 Package majority_pkg holds MODE_BITWISE/MODE_WORD constants and parameter range limits.
REQ-030 One sub-module, majority_bit: combinational N_CH-input popcount majority for one bit column, instantiated WIDTH times for MODE 0.
REQ-031 Parameter violations (even N_CH, out-of-range values) SHALL fail elaboration.

Verification (N_CH=3, WIDTH=8, FAULT_LIMIT=3)
REQ-032 MODE 0, inputs 0xF0,0xCC,0xAA, out_ready=1 -> next cycle data_out=0xE8, vote_ok=1, disagree=3'b111.
REQ-033 MODE 1, inputs 0x12,0x34,0x56 after prior result 0x77 -> data_out=0x77, vote_ok=0, disagree=3'b111, counters unchanged.
REQ-034 Channel 2 differs on 3 consecutive samples -> ch_fail=3'b100 after the third result; one matching sample -> ch_fail stays 3'b100; clear_fail -> 3'b000.
REQ-035 out_ready=0 for 4 cycles with in_valid=1 -> one result held stable, in_ready=0, no sample lost or duplicated after out_ready returns.
REQ-036 rst_n asserted between clock edges while out_valid=1 -> out_valid=0 and all outputs zero before the next edge.
REQ-037 clear_fail coincident with 3rd mismatching sample on channel 0 -> ch_fail stays 0, counter 0.
